// File: rtl/edge_event_pkg.sv
// Shared types and constants for the edge-event controller.
package edge_event_pkg;

  localparam int unsigned MaxChan     = 32;
  localparam int unsigned MaxChanIdxW = 5;

  localparam logic EdgeFall = 1'b0;
  localparam logic EdgeRise = 1'b1;

  // Channel field is sized for the largest supported channel count so the type
  // stays parameter-free; instances use the low ChanIdxW bits.
  typedef struct packed {
    logic [MaxChanIdxW-1:0] chan;
    logic                   rise;
  } evt_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_event_rr_arb.sv
// Round-robin picker: first request at or above rr_ptr, wrapping; pointer moves past the winner on advance.
module edge_event_rr_arb
  import edge_event_pkg::*;
#(
  parameter  int unsigned NumChan  = 8,
  localparam int unsigned ChanIdxW = idx_width(NumChan)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumChan-1:0]  req_i,
  input  logic                advance_i,
  output logic                gnt_valid_o,
  output logic [ChanIdxW-1:0] gnt_idx_o,
  output logic [NumChan-1:0]  gnt_oh_o
);

  logic [ChanIdxW-1:0] rr_ptr_q;
  logic [ChanIdxW-1:0] rr_ptr_d;

  always_comb begin
    int unsigned c;
    c           = 0;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    gnt_oh_o    = '0;
    for (int unsigned k = 0; k < NumChan; k++) begin
      c = 32'(rr_ptr_q) + k;
      if (c >= NumChan) begin
        c = c - NumChan;
      end
      if (!gnt_valid_o && req_i[c]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = ChanIdxW'(c);
        gnt_oh_o[c] = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance_i && gnt_valid_o) begin
      if (32'(gnt_idx_o) + 32'd1 == NumChan) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx_o + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/sync.sv
// Multi-flop synchronizer for one asynchronous level input.
module sync #(
  parameter int unsigned STAGES     = 2,
  parameter bit          ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic serial_i,
  output logic serial_o
);

  logic [STAGES-1:0] reg_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_q <= {STAGES{ResetValue}};
    end else begin
      reg_q <= {reg_q[STAGES-2:0], serial_i};
    end
  end

  assign serial_o = reg_q[STAGES-1];

endmodule

// File: rtl/edge_event_ctrl.sv
// Multi-channel edge detector with per-channel pending/overflow tracking and a
// round-robin valid/ready event port.
module edge_event_ctrl
  import edge_event_pkg::*;
#(
  parameter  int unsigned NumChan    = 8,
  parameter  int unsigned SyncStages = 2,
  localparam int unsigned ChanIdxW   = idx_width(NumChan)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumChan-1:0]  serial_i,
  input  logic [NumChan-1:0]  en_i,
  input  logic [NumChan-1:0]  rise_en_i,
  input  logic [NumChan-1:0]  fall_en_i,
  output logic [NumChan-1:0]  level_o,
  output logic [NumChan-1:0]  pending_o,
  output logic [NumChan-1:0]  overflow_o,
  input  logic [NumChan-1:0]  overflow_clr_i,
  output logic                evt_valid_o,
  input  logic                evt_ready_i,
  output logic [ChanIdxW-1:0] evt_chan_o,
  output logic                evt_rise_o
);

  logic                rst_n;
  logic [NumChan-1:0]  synced;
  logic [NumChan-1:0]  level_q;
  logic [NumChan-1:0]  rise;
  logic [NumChan-1:0]  fall;
  logic [NumChan-1:0]  qual;
  logic [NumChan-1:0]  pending_q, pending_d;
  logic [NumChan-1:0]  type_q, type_d;
  logic [NumChan-1:0]  overflow_q, overflow_d;
  logic [NumChan-1:0]  loaded;
  logic [NumChan-1:0]  gnt_oh;
  logic [ChanIdxW-1:0] gnt_idx;
  logic                gnt_valid;
  logic                load;
  logic                evt_valid_q;
  evt_t                evt_q;

  assign rst_n = ~rst_i;

  for (genvar i = 0; i < NumChan; i++) begin : g_sync
    sync #(
      .STAGES     (SyncStages),
      .ResetValue (1'b0)
    ) u_sync (
      .clk_i    (clk_i),
      .rst_ni   (rst_n),
      .serial_i (serial_i[i]),
      .serial_o (synced[i])
    );
  end

  // level_q tracks the input even while disabled, so re-enabling sees no stale edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q <= '0;
    end else begin
      level_q <= synced;
    end
  end

  assign rise = synced & ~level_q;
  assign fall = ~synced & level_q;
  assign qual = en_i & ((rise & rise_en_i) | (fall & fall_en_i));

  assign load   = !evt_valid_q || evt_ready_i;
  assign loaded = (load && gnt_valid) ? gnt_oh : '0;

  edge_event_rr_arb #(
    .NumChan (NumChan)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (pending_q),
    .advance_i   (load),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx),
    .gnt_oh_o    (gnt_oh)
  );

  // A channel being loaded this cycle frees its slot, so a simultaneous edge
  // takes it over instead of counting as lost.
  always_comb begin
    pending_d  = pending_q;
    type_d     = type_q;
    overflow_d = overflow_q;
    for (int unsigned i = 0; i < NumChan; i++) begin
      if (qual[i]) begin
        if (!pending_q[i] || loaded[i]) begin
          pending_d[i] = 1'b1;
          type_d[i]    = rise[i] ? EdgeRise : EdgeFall;
        end else begin
          overflow_d[i] = 1'b1;
        end
      end else if (loaded[i]) begin
        pending_d[i] = 1'b0;
      end
      if (overflow_clr_i[i] && !(qual[i] && pending_q[i] && !loaded[i])) begin
        overflow_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q  <= '0;
      type_q     <= '0;
      overflow_q <= '0;
    end else begin
      pending_q  <= pending_d;
      type_q     <= type_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      evt_valid_q <= 1'b0;
      evt_q       <= '0;
    end else if (load) begin
      evt_valid_q <= gnt_valid;
      if (gnt_valid) begin
        evt_q.chan <= MaxChanIdxW'(gnt_idx);
        evt_q.rise <= type_q[gnt_idx];
      end
    end
  end

  if (ChanIdxW < MaxChanIdxW) begin : g_pad
    logic unused_chan_hi;
    assign unused_chan_hi = |evt_q.chan[MaxChanIdxW-1:ChanIdxW];
  end

  assign level_o     = level_q;
  assign pending_o   = pending_q;
  assign overflow_o  = overflow_q;
  assign evt_valid_o = evt_valid_q;
  assign evt_chan_o  = evt_q.chan[ChanIdxW-1:0];
  assign evt_rise_o  = evt_q.rise;

endmodule

// File: tb/tb_edge_event_ctrl.sv
// Directed tables, hand sequences and a randomized run against a behavioural model.
module tb_edge_event_ctrl;

  localparam int N = 8;
  localparam int S = 2;

  logic         clk;
  logic         rst;
  logic [N-1:0] serial, en, rise_en, fall_en, ovf_clr;
  logic [N-1:0] level, pending, overflow;
  logic         ready, valid, rise;
  logic [2:0]   chan;

  int checks = 0;
  int errors = 0;

  edge_event_ctrl #(.NumChan(N), .SyncStages(S)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .serial_i       (serial),
    .en_i           (en),
    .rise_en_i      (rise_en),
    .fall_en_i      (fall_en),
    .level_o        (level),
    .pending_o      (pending),
    .overflow_o     (overflow),
    .overflow_clr_i (ovf_clr),
    .evt_valid_o    (valid),
    .evt_ready_i    (ready),
    .evt_chan_o     (chan),
    .evt_rise_o     (rise)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural model: a delay line for the synchronizer plus per-channel slots.
  bit [N-1:0] m_pipe [S];
  bit [N-1:0] m_lvl, m_pend, m_typ, m_ovf;
  bit         m_valid, m_rise;
  int         m_chan, m_ptr;
  bit         model_on = 0;

  int ev_ch[$];
  bit ev_ri[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < S; k++) m_pipe[k] = '0;
    m_lvl = '0; m_pend = '0; m_typ = '0; m_ovf = '0;
    m_valid = 0; m_rise = 0; m_chan = 0; m_ptr = 0;
  endtask

  task automatic step();
    bit [N-1:0] sy, ri, fa, q, np, nt, no, sv;
    bit ld, was_rst;
    int w;
    sy = m_pipe[S-1];
    sv = serial;
    ri = sy & ~m_lvl;
    fa = ~sy & m_lvl;
    q  = en & ((ri & rise_en) | (fa & fall_en));
    ld = !m_valid || ready;
    w  = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (w < 0 && m_pend[c]) w = c;
    end
    np = m_pend; nt = m_typ; no = m_ovf;
    for (int c = 0; c < N; c++) begin
      bit grab, lost;
      grab = ld && (w == c);
      lost = q[c] && m_pend[c] && !grab;
      if (q[c] && !lost) begin np[c] = 1; nt[c] = ri[c]; end
      else if (!q[c] && grab) np[c] = 0;
      if (lost) no[c] = 1;
      else if (ovf_clr[c]) no[c] = 0;
    end
    @(posedge clk);
    was_rst = rst;
    #1;
    if (was_rst || rst) begin
      model_reset();
    end else begin
      if (ld) begin
        if (w >= 0) begin
          m_valid = 1; m_chan = w; m_rise = m_typ[w]; m_ptr = (w + 1) % N;
        end else begin
          m_valid = 0;
        end
      end
      m_pend = np; m_typ = nt; m_ovf = no;
      for (int k = S - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = sv;
      m_lvl = sy;
    end
    if (model_on) begin
      chk("rnd_level", level, m_lvl);
      chk("rnd_pending", pending, m_pend);
      chk("rnd_overflow", overflow, m_ovf);
      chk("rnd_valid", valid, m_valid);
      if (m_valid) begin
        chk("rnd_chan", chan, m_chan);
        chk("rnd_rise", rise, m_rise);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic collect(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      if (valid === 1'b1) begin
        ev_ch.push_back(int'(chan));
        ev_ri.push_back(rise);
      end
    end
  endtask

  task automatic wait_valid(input string nm, input int maxc);
    int n;
    n = 0;
    while (valid !== 1'b1 && n < maxc) begin
      step();
      n++;
    end
    chk(nm, valid, 1);
  endtask

  typedef struct {
    int ch;
    bit en;
    bit ren;
    bit fen;
    bit pulse;
    int exp_n;
    bit exp_rise;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int seen;
    tbl[0] = '{ch: 6, en: 0, ren: 1, fen: 1, pulse: 1, exp_n: 0, exp_rise: 0};
    tbl[1] = '{ch: 2, en: 1, ren: 0, fen: 1, pulse: 1, exp_n: 1, exp_rise: 0};
    tbl[2] = '{ch: 5, en: 1, ren: 1, fen: 0, pulse: 1, exp_n: 1, exp_rise: 1};
    tbl[3] = '{ch: 7, en: 1, ren: 1, fen: 1, pulse: 1, exp_n: 2, exp_rise: 1};
    tbl[4] = '{ch: 1, en: 1, ren: 1, fen: 1, pulse: 0, exp_n: 1, exp_rise: 1};
    tbl[5] = '{ch: 0, en: 1, ren: 0, fen: 0, pulse: 1, exp_n: 0, exp_rise: 0};

    rst = 1; serial = '0; en = '1; rise_en = '1; fall_en = '1; ovf_clr = '0; ready = 0;
    model_reset();
    #3;
    chk("reset_valid", valid, 0);
    chk("reset_pending", pending, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_level", level, 0);
    chk("reset_chan", chan, 0);
    chk("reset_rise", rise, 0);

    // Single-channel latency
    do_reset();
    rise_en = 8'h08; fall_en = '0; ready = 0;
    serial[3] = 1;
    step(); chk("lat_e0_valid", valid, 0);
    step(); chk("lat_e1_pend", pending[3], 0);
    step(); chk("lat_e2_pend", pending[3], 1); chk("lat_e2_valid", valid, 0);
    step();
    chk("lat_e3_valid", valid, 1);
    chk("lat_e3_chan", chan, 3);
    chk("lat_e3_rise", rise, 1);
    chk("lat_e3_pend_clr", pending[3], 0);
    ready = 1;
    step(); chk("lat_drain_valid", valid, 0);

    // Round-robin from pointer 0, then from pointer 3
    do_reset();
    rise_en = '1; fall_en = '0; ready = 1;
    ev_ch.delete(); ev_ri.delete();
    serial = 8'h25;
    collect(8);
    chk("rr0_count", ev_ch.size(), 3);
    if (ev_ch.size() == 3) begin
      chk("rr0_ev0", ev_ch[0], 0);
      chk("rr0_ev1", ev_ch[1], 2);
      chk("rr0_ev2", ev_ch[2], 5);
    end
    serial = '0;
    repeat (4) step();
    ev_ch.delete(); ev_ri.delete();
    serial[2] = 1;
    collect(6);
    chk("rr_prep_count", ev_ch.size(), 1);
    serial = '0;
    repeat (4) step();
    ev_ch.delete(); ev_ri.delete();
    serial = 8'h25;
    collect(8);
    chk("rr3_count", ev_ch.size(), 3);
    if (ev_ch.size() == 3) begin
      chk("rr3_ev0", ev_ch[0], 5);
      chk("rr3_ev1", ev_ch[1], 0);
      chk("rr3_ev2", ev_ch[2], 2);
    end

    // Backpressure, overflow and clear
    do_reset();
    rise_en = 8'h02; fall_en = 8'h02; ready = 0;
    serial[1] = 1;
    wait_valid("bp_first_valid", 8);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) serial[1] = 0;
      if (i == 4) serial[1] = 1;
      step();
      chk("bp_hold_valid", valid, 1);
      chk("bp_hold_chan", chan, 1);
      chk("bp_hold_rise", rise, 1);
    end
    chk("bp_overflow_set", overflow[1], 1);
    chk("bp_pending_set", pending[1], 1);
    ovf_clr = 8'h02;
    step();
    ovf_clr = '0;
    chk("bp_overflow_clr", overflow[1], 0);
    chk("bp_pending_kept", pending[1], 1);
    ready = 1;
    step();
    chk("bp_second_valid", valid, 1);
    chk("bp_second_chan", chan, 1);
    chk("bp_second_rise", rise, 0);
    step();
    chk("bp_drain_valid", valid, 0);

    // Edge on the cycle its channel is loaded
    do_reset();
    rise_en = 8'h11; fall_en = 8'h10; ready = 0;
    serial[0] = 1;
    wait_valid("col_first_valid", 8);
    chk("col_first_chan", chan, 0);
    serial[4] = 1;
    repeat (4) step();
    chk("col_pend_pre", pending[4], 1);
    serial[4] = 0;
    step(); step();
    ready = 1;
    step();
    ready = 0;
    chk("col_valid", valid, 1);
    chk("col_chan", chan, 4);
    chk("col_rise", rise, 1);
    chk("col_pend_kept", pending[4], 1);
    chk("col_no_overflow", overflow[4], 0);
    ready = 1;
    step();
    chk("col_second_valid", valid, 1);
    chk("col_second_chan", chan, 4);
    chk("col_second_rise", rise, 0);
    step();
    chk("col_drain_valid", valid, 0);
    chk("col_drain_pend", pending[4], 0);

    // Table: enable / edge-type masking
    for (int t = 0; t < 6; t++) begin
      do_reset();
      en = '1; en[tbl[t].ch] = tbl[t].en;
      rise_en = '0; rise_en[tbl[t].ch] = tbl[t].ren;
      fall_en = '0; fall_en[tbl[t].ch] = tbl[t].fen;
      ready = 1;
      ev_ch.delete(); ev_ri.delete();
      serial[tbl[t].ch] = 1;
      collect(5);
      if (tbl[t].pulse) serial[tbl[t].ch] = 0;
      collect(6);
      chk($sformatf("tbl%0d_count", t), ev_ch.size(), tbl[t].exp_n);
      if (tbl[t].exp_n > 0 && ev_ch.size() > 0) begin
        chk($sformatf("tbl%0d_chan", t), ev_ch[0], tbl[t].ch);
        chk($sformatf("tbl%0d_rise", t), ev_ri[0], tbl[t].exp_rise);
      end
      serial = '0;
    end

    // Re-enable after a transition while disabled
    do_reset();
    en = 8'hBF; rise_en = '1; fall_en = '1; ready = 1;
    serial[6] = 1;
    repeat (5) step();
    en = '1;
    ev_ch.delete(); ev_ri.delete();
    collect(6);
    chk("reen_no_event", ev_ch.size(), 0);
    chk("reen_level", level[6], 1);
    serial = '0;

    // Asynchronous reset while an event is stalled
    do_reset();
    en = '1; rise_en = '1; fall_en = '0; ready = 0;
    serial = 8'h0C;
    wait_valid("ar_valid", 8);
    step();
    chk("ar_chan", chan, 2);
    chk("ar_pend", pending, 8'h08);
    #2;
    rst = 1; serial = '0;
    #1;
    chk("ar_valid_clr", valid, 0);
    chk("ar_pend_clr", pending, 0);
    chk("ar_ovf_clr", overflow, 0);
    chk("ar_level_clr", level, 0);
    chk("ar_chan_clr", chan, 0);
    chk("ar_rise_clr", rise, 0);
    step();
    rst = 0;
    seen = 0;
    repeat (8) begin
      step();
      if (valid !== 1'b0) seen = 1;
    end
    chk("ar_no_event", seen, 0);
    rst = 1; serial = 8'h08;
    step(); step();
    rst = 0;
    wait_valid("rel_high_valid", 8);
    chk("rel_high_chan", chan, 3);
    chk("rel_high_rise", rise, 1);

    // Randomized run against the model
    serial = '0; en = '1; rise_en = '1; fall_en = '1; ovf_clr = '0; ready = 1;
    do_reset();
    model_on = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7, 0) == 0) serial[b] = ~serial[b];
      end
      ready = ($urandom_range(9, 0) < 7);
      if ($urandom_range(49, 0) == 0) en = N'($urandom);
      if ($urandom_range(49, 0) == 0) rise_en = N'($urandom);
      if ($urandom_range(49, 0) == 0) fall_en = N'($urandom);
      ovf_clr = ($urandom_range(19, 0) == 0) ? N'($urandom) : '0;
      step();
    end
    model_on = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
